// File: rtl/wgt_fetch_sched.sv
// Weight fetch scheduler: splits one weight region into memory read commands,
// caps the number of bursts in flight, and reports completion once every
// issued burst has returned its last data beat.
module wgt_fetch_sched #(
  parameter int NUM_PE          = 8,
  parameter int W_BW            = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] total_bytes,
  input  logic [22:0] max_burst_bytes,
  output logic        m_axis_cmd_tvalid,
  input  logic        m_axis_cmd_tready,
  output logic [79:0] m_axis_cmd_tdata,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tlast,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int BEAT_B = NUM_PE * W_BW / 8;
  localparam int OS_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OS_W-1:0] OS_MAX   = OS_W'(MAX_OUTSTANDING);
  localparam logic [31:0]     BEAT_B32 = 32'(BEAT_B);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q;
  logic [31:0]    addr_q;
  logic [31:0]    remaining_q;
  logic [22:0]    max_burst_q;
  logic [3:0]     tag_q;
  logic [OS_W-1:0] outstanding_q;

  logic            cmd_hs;
  logic            burst_done;
  logic            burst_ok;
  logic            stray_tlast;
  logic [OS_W-1:0] outstanding_nxt;
  logic            can_issue_nxt;
  logic            start_legal;
  logic [22:0]     cur_btt;
  logic [31:0]     rem_after;
  logic [31:0]     addr_after;
  logic [3:0]      tag_after;

  // A command carries at most max_burst bytes, fewer for the final tail.
  function automatic logic [22:0] min_btt(input logic [31:0] rem, input logic [22:0] maxb);
    if (rem < {9'd0, maxb}) return rem[22:0];
    else                    return maxb;
  endfunction

  // Command word layout: BTT, incrementing-burst and EOF flags, address, tag.
  function automatic logic [79:0] build_cmd(input logic [31:0] addr, input logic [22:0] btt,
                                            input logic [3:0] tag);
    return {12'd0, tag, addr, 1'b0, 1'b1, 6'd0, 1'b1, btt};
  endfunction

  // Handshake decode, outstanding-burst bookkeeping and next-command arithmetic.
  always_comb begin
    cmd_hs          = m_axis_cmd_tvalid & m_axis_cmd_tready;
    burst_done      = mon_tvalid & mon_tready & mon_tlast;
    burst_ok        = burst_done && (outstanding_q != '0);
    stray_tlast     = burst_done && (outstanding_q == '0);
    outstanding_nxt = outstanding_q + OS_W'(cmd_hs) - OS_W'(burst_ok);
    can_issue_nxt   = (outstanding_nxt < OS_MAX);
    start_legal     = (total_bytes != 32'd0) && (max_burst_bytes != 23'd0) &&
                      ((total_bytes % BEAT_B32) == 32'd0) &&
                      (({9'd0, max_burst_bytes} % BEAT_B32) == 32'd0);
    cur_btt         = min_btt(remaining_q, max_burst_q);
    rem_after       = remaining_q - {9'd0, cur_btt};
    addr_after      = addr_q + {9'd0, cur_btt};
    tag_after       = tag_q + 4'd1;
  end

  // Region FSM with all outputs registered; tvalid is only raised when the
  // outstanding count after this edge still leaves room for another burst.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      remaining_q       <= '0;
      max_burst_q       <= '0;
      tag_q             <= '0;
      outstanding_q     <= '0;
      m_axis_cmd_tvalid <= 1'b0;
      m_axis_cmd_tdata  <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      done          <= 1'b0;
      err           <= stray_tlast;
      outstanding_q <= outstanding_nxt;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_legal) begin
              addr_q            <= base_addr;
              remaining_q       <= total_bytes;
              max_burst_q       <= max_burst_bytes;
              tag_q             <= 4'd0;
              busy              <= 1'b1;
              m_axis_cmd_tvalid <= 1'b1;
              m_axis_cmd_tdata  <= build_cmd(base_addr, min_btt(total_bytes, max_burst_bytes), 4'd0);
              state_q           <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd_hs) begin
            addr_q      <= addr_after;
            remaining_q <= rem_after;
            tag_q       <= tag_after;
            if (rem_after == 32'd0) begin
              m_axis_cmd_tvalid <= 1'b0;
              state_q           <= DRAIN;
            end else begin
              m_axis_cmd_tvalid <= can_issue_nxt;
              m_axis_cmd_tdata  <= build_cmd(addr_after, min_btt(rem_after, max_burst_q), tag_after);
            end
          end else begin
            m_axis_cmd_tvalid <= can_issue_nxt;
          end
        end
        DRAIN: begin
          if (outstanding_nxt == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wgt_fetch_sched.sv
// Directed bench for the weight fetch scheduler: drives regions through the
// start/command/monitor ports and compares against hand-computed commands.
module tb_wgt_fetch_sched;

  logic        s_axi_aclk;
  logic        s_axi_aresetn;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] total_bytes;
  logic [22:0] max_burst_bytes;
  logic        m_axis_cmd_tvalid;
  logic        m_axis_cmd_tready;
  logic [79:0] m_axis_cmd_tdata;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic        busy;
  logic        done;
  logic        err;

  int error_count;
  int check_count;

  wgt_fetch_sched #(.NUM_PE(8), .W_BW(8), .MAX_OUTSTANDING(4)) dut (
    .s_axi_aclk        (s_axi_aclk),
    .s_axi_aresetn     (s_axi_aresetn),
    .start             (start),
    .base_addr         (base_addr),
    .total_bytes       (total_bytes),
    .max_burst_bytes   (max_burst_bytes),
    .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
    .m_axis_cmd_tready (m_axis_cmd_tready),
    .m_axis_cmd_tdata  (m_axis_cmd_tdata),
    .mon_tvalid        (mon_tvalid),
    .mon_tready        (mon_tready),
    .mon_tlast         (mon_tlast),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  // Free-running 100 MHz clock.
  initial s_axi_aclk = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  // Hard stop in case the run ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [79:0] exp_cmd(input logic [22:0] btt, input logic [31:0] addr,
                                          input logic [3:0] tag);
    logic [79:0] v;
    v         = '0;
    v[22:0]   = btt;
    v[23]     = 1'b1;
    v[30]     = 1'b1;
    v[63:32]  = addr;
    v[67:64]  = tag;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [79:0] actual, input logic [79:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  // Present a one-cycle start request with the given region parameters.
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] t, input logic [22:0] m);
    base_addr       = b;
    total_bytes     = t;
    max_burst_bytes = m;
    start           = 1'b1;
    tick();
    start           = 1'b0;
  endtask

  // Return one burst-complete beat on the monitored data stream.
  task automatic sendTlast();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b1;
    tick();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  initial begin
    logic [79:0] held;
    error_count       = 0;
    check_count       = 0;
    start             = 1'b0;
    base_addr         = '0;
    total_bytes       = '0;
    max_burst_bytes   = '0;
    m_axis_cmd_tready = 1'b1;
    mon_tvalid        = 1'b0;
    mon_tready        = 1'b0;
    mon_tlast         = 1'b0;
    s_axi_aresetn     = 1'b0;
    repeat (3) tick();
    checkOutput("rst_tvalid", m_axis_cmd_tvalid, 0);
    checkOutput("rst_tdata", m_axis_cmd_tdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    tick();

    // Single command region, then back-to-back start after done.
    $display("[TB] single-burst region");
    applyStimulus(32'h1000, 32'd64, 23'd64);
    checkOutput("r1_busy", busy, 1);
    checkOutput("r1_tvalid", m_axis_cmd_tvalid, 1);
    checkOutput("r1_cmd0", m_axis_cmd_tdata, exp_cmd(23'd64, 32'h1000, 4'd0));
    tick();
    checkOutput("r1_drain_tvalid", m_axis_cmd_tvalid, 0);
    checkOutput("r1_drain_busy", busy, 1);
    sendTlast();
    checkOutput("r1_done", done, 1);
    checkOutput("r1_busy_off", busy, 0);

    // Multi-burst region with a short tail, started right after done.
    $display("[TB] four-burst region with tail");
    applyStimulus(32'h0, 32'd200, 23'd64);
    checkOutput("r2_done_clear", done, 0);
    for (int i = 0; i < 4; i++) begin
      logic [22:0] b;
      b = (i == 3) ? 23'd8 : 23'd64;
      checkOutput($sformatf("r2_tvalid%0d", i), m_axis_cmd_tvalid, 1);
      checkOutput($sformatf("r2_cmd%0d", i), m_axis_cmd_tdata,
                  exp_cmd(b, 32'(i * 64), 4'(i)));
      tick();
    end
    checkOutput("r2_tvalid_end", m_axis_cmd_tvalid, 0);
    for (int i = 0; i < 4; i++) begin
      sendTlast();
      checkOutput($sformatf("r2_done%0d", i), done, (i == 3) ? 1 : 0);
      checkOutput($sformatf("r2_busy%0d", i), busy, (i == 3) ? 0 : 1);
    end

    // Outstanding limit: four bursts in flight stall the fifth command.
    $display("[TB] outstanding limit");
    applyStimulus(32'h2000, 32'd384, 23'd64);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("r3_cmd%0d", i), m_axis_cmd_tdata,
                  exp_cmd(23'd64, 32'h2000 + 32'(i * 64), 4'(i)));
      tick();
    end
    checkOutput("r3_stall0", m_axis_cmd_tvalid, 0);
    tick();
    checkOutput("r3_stall1", m_axis_cmd_tvalid, 0);
    sendTlast();
    checkOutput("r3_resume_tvalid", m_axis_cmd_tvalid, 1);
    checkOutput("r3_cmd4", m_axis_cmd_tdata, exp_cmd(23'd64, 32'h2100, 4'd4));
    tick();
    checkOutput("r3_stall2", m_axis_cmd_tvalid, 0);
    sendTlast();
    checkOutput("r3_cmd5", m_axis_cmd_tdata, exp_cmd(23'd64, 32'h2140, 4'd5));
    tick();
    checkOutput("r3_drain_tvalid", m_axis_cmd_tvalid, 0);
    for (int i = 0; i < 4; i++) begin
      sendTlast();
      checkOutput($sformatf("r3_done%0d", i), done, (i == 3) ? 1 : 0);
    end

    // Backpressure: command held stable while tready is low.
    $display("[TB] backpressure");
    m_axis_cmd_tready = 1'b0;
    applyStimulus(32'h3000, 32'd128, 23'd64);
    held = exp_cmd(23'd64, 32'h3000, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("r4_hold_tvalid%0d", i), m_axis_cmd_tvalid, 1);
      checkOutput($sformatf("r4_hold_tdata%0d", i), m_axis_cmd_tdata, held);
    end
    m_axis_cmd_tready = 1'b1;
    tick();
    m_axis_cmd_tready = 1'b0;
    checkOutput("r4_cmd1", m_axis_cmd_tdata, exp_cmd(23'd64, 32'h3040, 4'd1));
    tick();
    checkOutput("r4_cmd1_hold", m_axis_cmd_tdata, exp_cmd(23'd64, 32'h3040, 4'd1));
    checkOutput("r4_cmd1_tvalid", m_axis_cmd_tvalid, 1);
    m_axis_cmd_tready = 1'b1;
    tick();
    checkOutput("r4_drain_tvalid", m_axis_cmd_tvalid, 0);
    sendTlast();
    checkOutput("r4_done_early", done, 0);
    sendTlast();
    checkOutput("r4_done", done, 1);

    // Illegal region parameters and a stray tlast.
    $display("[TB] illegal inputs");
    applyStimulus(32'h0, 32'd12, 23'd64);
    checkOutput("e1_err", err, 1);
    checkOutput("e1_tvalid", m_axis_cmd_tvalid, 0);
    checkOutput("e1_busy", busy, 0);
    tick();
    checkOutput("e1_err_clear", err, 0);
    checkOutput("e1_busy_after", busy, 0);
    applyStimulus(32'h0, 32'd64, 23'd0);
    checkOutput("e2_err", err, 1);
    checkOutput("e2_busy", busy, 0);
    applyStimulus(32'h0, 32'd0, 23'd64);
    checkOutput("e3_err", err, 1);
    applyStimulus(32'h0, 32'd64, 23'd12);
    checkOutput("e4_err", err, 1);
    tick();
    sendTlast();
    checkOutput("e5_stray_err", err, 1);
    checkOutput("e5_busy", busy, 0);

    // Asynchronous reset mid-region, then a fresh region.
    $display("[TB] reset mid-region");
    applyStimulus(32'h4000, 32'd256, 23'd64);
    tick();
    tick();
    checkOutput("r5_cmd2", m_axis_cmd_tdata, exp_cmd(23'd64, 32'h4080, 4'd2));
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    checkOutput("r5_rst_tvalid", m_axis_cmd_tvalid, 0);
    checkOutput("r5_rst_tdata", m_axis_cmd_tdata, 0);
    checkOutput("r5_rst_busy", busy, 0);
    checkOutput("r5_rst_done", done, 0);
    checkOutput("r5_rst_err", err, 0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    tick();
    applyStimulus(32'h5000, 32'd64, 23'd64);
    checkOutput("r6_cmd0", m_axis_cmd_tdata, exp_cmd(23'd64, 32'h5000, 4'd0));
    checkOutput("r6_busy", busy, 1);
    tick();
    sendTlast();
    checkOutput("r6_done", done, 1);
    checkOutput("r6_err", err, 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/wgt_fetch_sched.md
WGT_FETCH_SCHED -- requirements
Module: wgt_fetch_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_PE, default 8, the number of PEs per weight beat.
REQ-002 The block SHALL have parameter W_BW, default 8, the bits per weight; beat size BEAT_B = NUM_PE*W_BW/8 bytes.
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of issued but uncompleted bursts.
Ports (name, direction, width, meaning; clock and reset first):
REQ-004 s_axi_aclk  in  1  the single clock; all logic SHALL be rising-edge.
REQ-005 s_axi_aresetn  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  one-cycle request to fetch one weight region.
REQ-007 base_addr  in  32  byte start address, sampled on accepted start.
REQ-008 total_bytes  in  32  region length in bytes, sampled on accepted start.
REQ-009 max_burst_bytes  in  23  maximum bytes per command, sampled on accepted start.
REQ-010 m_axis_cmd_tvalid / m_axis_cmd_tready / m_axis_cmd_tdata  out / in / out  1/1/80  command stream to the weight memory.
REQ-011 mon_tvalid / mon_tready / mon_tlast  in  1/1/1  passive snoop of the weight data stream handshake.
REQ-012 busy / done / err  out  1/1/1  busy = a region is in progress; done and err = one-cycle pulses.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ISSUE and DRAIN.
REQ-014 In IDLE, start=1 SHALL register the inputs; if the inputs are legal, the FSM SHALL go to ISSUE and busy SHALL be 1 from the next cycle.
REQ-015 Illegal inputs (total_bytes=0, max_burst_bytes=0, or either not a multiple of BEAT_B) SHALL pulse err for one cycle, issue no command, and leave the FSM in IDLE.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 Each command's BTT SHALL be min(remaining, max_burst_bytes); after each accepted command, remaining SHALL decrease by BTT and the address SHALL increase by BTT (32-bit wrap).
REQ-018 Command tdata SHALL be: [22:0]=BTT, [23]=1, [29:24]=0, [30]=1, [31]=0, [63:32]=address, [67:64]=tag, [79:68]=0.
REQ-019 The tag SHALL equal the command index within the region, modulo 16, starting at 0.
REQ-020 m_axis_cmd_tvalid SHALL first assert in the cycle after start is accepted.
REQ-021 tdata SHALL be held stable while tvalid=1 and tready=0, and tvalid SHALL NOT drop before the handshake.
REQ-022 The outstanding counter SHALL increment on a cmd handshake and decrement on mon_tvalid&mon_tready&mon_tlast; if both occur in the same cycle, it SHALL be unchanged.
REQ-023 tvalid SHALL be 0 whenever outstanding == MAX_OUTSTANDING.
REQ-024 A new command MAY be presented in the same cycle a burst completes.
REQ-025 When the last command handshakes (remaining becomes 0), the FSM SHALL go ISSUE->DRAIN.
REQ-026 In DRAIN, when outstanding reaches 0, done SHALL pulse for one cycle, busy SHALL deassert in that same cycle, and the FSM SHALL go to IDLE.
REQ-027 A tlast arriving with outstanding=0 SHALL be ignored (no underflow) and SHALL pulse err.
REQ-028 Back-to-back regions SHALL be possible: start may be accepted in the cycle after done.

Reset
REQ-029 On s_axi_aresetn=0, the block SHALL immediately, at any point including mid-burst, set: FSM=IDLE, outstanding=0, tag=0, remaining=0, m_axis_cmd_tvalid=0, m_axis_cmd_tdata=0, busy=0, done=0, err=0.
REQ-030 After reset release, the first accepted start SHALL behave as a fresh region.

Verification
REQ-031 base_addr=0x1000, total_bytes=64, max_burst_bytes=64, tready=1 -> one command, BTT=64, addr=0x1000, tag=0; one tlast -> done pulses once, busy=0.
REQ-032 base_addr=0, total_bytes=200, max_burst_bytes=64 -> BTT 64,64,64,8 at addresses 0x0,0x40,0x80,0xC0 with tags 0..3; done only after the 4th tlast.
REQ-033 total_bytes=384, max_burst_bytes=64, no tlast returned -> exactly 4 commands, then tvalid=0; one tlast -> the 5th command is presented the next cycle.
REQ-034 tready held 0 for 5 cycles with tvalid=1 -> tdata unchanged across all 5 cycles; a single handshake occurs when tready=1.
REQ-035 total_bytes=12 (not a multiple of 8) -> err pulse one cycle, no command, busy stays 0.
REQ-036 aresetn asserted after the 2nd of 4 commands -> all outputs take their reset values immediately; a new start after release produces tag 0 at the new base_addr.
